// File: rtl/wib_pkg.sv
// rtl/wib_pkg.sv - shared constants and FSM state type for the WIB read controller.
package wib_pkg;

  localparam int WIB_AW = 10;
  localparam int WIB_DW = 32;
  localparam int unsigned WIB_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wib_state_e;

endpackage

// File: rtl/wib_skid_fifo.sv
// rtl/wib_skid_fifo.sv - 2-entry FIFO that absorbs SRAM returns under downstream stall.
module wib_skid_fifo
  import wib_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [WIB_FIFO_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         pop_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage is reset too so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/wib_rd_ctrl.sv
// rtl/wib_rd_ctrl.sv - burst read controller: WIB SRAM port B to a valid/ready weight stream.
module wib_rd_ctrl
  import wib_pkg::*;
#(
  parameter int AW = WIB_AW,
  parameter int DW = WIB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW:0]   cmd_len,
  output logic          sram_enb,
  output logic [AW-1:0] sram_addrb,
  input  logic [DW-1:0] sram_doutb,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam logic [2:0] CREDITS = 3'(WIB_FIFO_DEPTH);

  wib_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          inflight_q, tag_last_q;
  logic [1:0]    fifo_cnt;
  logic [DW:0]   fifo_head;
  logic [2:0]    occ;
  logic          pop, issue, cmd_fire, final_word;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = ~cmd_ready;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign out_valid  = (fifo_cnt != 2'd0);
  assign pop        = out_valid && out_ready;
  assign out_data   = fifo_head[DW-1:0];
  assign out_last   = fifo_head[DW];
  assign final_word = (rem_q == {{AW{1'b0}}, 1'b1});

  // A same-cycle pop frees a slot, so credit is checked against occ - pop.
  assign occ      = {1'b0, fifo_cnt} + {2'b00, inflight_q};
  assign issue    = (state_q == ST_RUN) && (occ < CREDITS + {2'b00, pop});
  assign sram_enb = issue;
  assign sram_addrb = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire && (cmd_len != '0)) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          rem_d = rem_q - {{AW{1'b0}}, 1'b1};
          // Address stays on the final word so sram_addrb keeps the last read address.
          if (final_word) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      tag_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
      tag_last_q <= issue && final_word;
    end
  end

  wib_skid_fifo #(
    .W (DW + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .wdata_i ({tag_last_q, sram_doutb}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt)
  );

endmodule

// File: tb/tb_wib_rd_ctrl.sv
// tb/tb_wib_rd_ctrl.sv - directed bench for wib_rd_ctrl with an SRAM model returning data = address.
module tb_wib_rd_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          sram_enb;
  logic [AW-1:0] sram_addrb;
  logic [DW-1:0] sram_doutb = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  wib_rd_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .sram_enb   (sram_enb),
    .sram_addrb (sram_addrb),
    .sram_doutb (sram_doutb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_enb) sram_doutb <= DW'(sram_addrb);
  end

  logic [DW:0]   words[$];
  logic [AW-1:0] addrs[$];
  int issued = 0, popped = 0, max_occ = 0, stall_err = 0, valid_seen = 0;
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_word = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(out_valid && ({out_last, out_data} == prev_word))) stall_err++;
      if (out_valid) valid_seen++;
      if (sram_enb) begin
        issued++;
        addrs.push_back(sram_addrb);
      end
      if (out_valid && out_ready) begin
        popped++;
        words.push_back({out_last, out_data});
      end
      if (issued - popped > max_occ) max_occ = issued - popped;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    words.delete();
    addrs.delete();
    issued = 0;
    popped = 0;
    max_occ = 0;
    stall_err = 0;
    valid_seen = 0;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [AW:0] l);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_cyc;
    int lasts;

    // Reset values
    step();
    step();
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_sram_enb", 64'(sram_enb), 64'd0);
    chk("rst_sram_addrb", 64'(sram_addrb), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    step();

    // Single burst, cycle-exact timing
    clr();
    send(10'h010, 11'd4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("t_enb", 64'(sram_enb), 64'(c >= 1 && c <= 4));
      if (c <= 4) chk("t_addrb", 64'(sram_addrb), 64'(10'h010 + c - 1));
      chk("t_valid", 64'(out_valid), 64'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        chk("t_data", 64'(out_data), 64'(32'h10 + c - 3));
        chk("t_last", 64'(out_last), 64'(c == 6));
      end
      chk("t_cmd_ready", 64'(cmd_ready), 64'(c == 7));
      chk("t_busy", 64'(busy), 64'(c != 7));
      step();
    end

    // Address wrap
    clr();
    send(10'h3FE, 11'd4);
    wait_idle(50);
    chk("wrap_nreads", 64'(addrs.size()), 64'd4);
    chk("wrap_a0", 64'(addrs[0]), 64'h3FE);
    chk("wrap_a1", 64'(addrs[1]), 64'h3FF);
    chk("wrap_a2", 64'(addrs[2]), 64'h000);
    chk("wrap_a3", 64'(addrs[3]), 64'h001);
    chk("wrap_w2", 64'(words[2]), 64'h0_0000_0000);
    chk("wrap_w3", 64'(words[3]), 64'h1_0000_0001);

    // Maximum length
    clr();
    send(10'h200, 11'd1024);
    wait_idle(1100);
    lasts = 0;
    foreach (words[i]) if (words[i][DW]) lasts++;
    chk("max_nwords", 64'(words.size()), 64'd1024);
    chk("max_nlast", 64'(lasts), 64'd1);
    chk("max_first", 64'(words[0]), 64'h0_0000_0200);
    chk("max_wrapped", 64'(words[512]), 64'h0_0000_0000);
    chk("max_final", 64'(words[1023]), 64'h1_0000_01FF);

    // Backpressure: 10 stalled cycles, then random ready
    clr();
    send(10'h050, 11'd8);
    for (int c = 1; c <= 200 && busy; c++) begin
      if (c >= 3 && c <= 12) out_ready = 1'b0;
      else if (c == 13) out_ready = 1'b1;
      else out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 12) chk("bp_no_issue_stalled", 64'(sram_enb), 64'd0);
      if (c == 13) chk("bp_resume_issue", 64'(sram_enb), 64'd1);
      step();
    end
    out_ready = 1'b1;
    wait_idle(50);
    chk("bp_nwords", 64'(words.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk("bp_word", 64'(words[i]), {31'd0, (i == 7), 32'h50 + 32'(i)});
    chk("bp_max_occ", 64'(max_occ), 64'd2);
    chk("bp_stall_stable", 64'(stall_err), 64'd0);

    // Zero length
    clr();
    send(10'h055, 11'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_enb", 64'(sram_enb), 64'd0);
      step();
    end
    chk("zero_issued", 64'(issued), 64'd0);

    // Command held during a burst is accepted only once idle
    clr();
    send(10'h100, 11'd4);
    cmd_addr  = 10'h300;
    cmd_len   = 11'd2;
    cmd_valid = 1'b1;
    acc_cyc   = -1;
    for (int c = 1; c <= 20 && acc_cyc < 0; c++) begin
      @(negedge clk);
      if (cmd_ready) acc_cyc = c;
      step();
    end
    cmd_valid = 1'b0;
    chk("busy_accept_cycle", 64'(acc_cyc), 64'd7);
    wait_idle(50);
    chk("busy_nwords", 64'(words.size()), 64'd6);
    chk("busy_w3", 64'(words[3]), 64'h1_0000_0103);
    chk("busy_w4", 64'(words[4]), 64'h0_0000_0300);
    chk("busy_w5", 64'(words[5]), 64'h1_0000_0301);

    // Reset mid-burst, then a fresh short burst
    clr();
    send(10'h020, 11'd8);
    step();
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_enb", 64'(sram_enb), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    step();
    rst_n = 1'b1;
    clr();
    for (int c = 0; c < 6; c++) step();
    chk("mid_rst_quiet_valid", 64'(valid_seen), 64'd0);
    chk("mid_rst_quiet_reads", 64'(issued), 64'd0);
    send(10'h030, 11'd2);
    wait_idle(50);
    chk("post_rst_nwords", 64'(words.size()), 64'd2);
    chk("post_rst_w0", 64'(words[0]), 64'h0_0000_0030);
    chk("post_rst_w1", 64'(words[1]), 64'h1_0000_0031);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
